rvfi_commit_sequencer: RTL and testbench

RVFI_COMMIT_SEQUENCER -- requirements
Module: rvfi_commit_sequencer

---
 rtl/riscv.sv | 4 +
 rtl/rvfi_pkg.sv | 27 ++
 rtl/rvfi_commit_sequencer.sv | 152 +++++++++++++++
 tb/tb_rvfi_commit_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv.sv
// Minimal RISC-V architectural constants used by the commit sequencer.
package riscv;
   localparam int XLEN = 64;
endpackage

// File: rtl/rvfi_pkg.sv
// RVFI commit record layout as produced by the core, one record per retired
// (or trapped) instruction per commit port.
package rvfi_pkg;
   typedef struct packed {
      logic                     valid;
      logic [63:0]              order;
      logic [31:0]              insn;
      logic                     trap;
      logic [riscv::XLEN-1:0]   cause;
      logic                     halt;
      logic                     intr;
      logic [1:0]               mode;
      logic [4:0]               rs1_addr;
      logic [4:0]               rs2_addr;
      logic [4:0]               rd_addr;
      logic [riscv::XLEN-1:0]   rs1_rdata;
      logic [riscv::XLEN-1:0]   rs2_rdata;
      logic [riscv::XLEN-1:0]   rd_wdata;
      logic [riscv::XLEN-1:0]   pc_rdata;
      logic [riscv::XLEN-1:0]   pc_wdata;
      logic [riscv::XLEN-1:0]   mem_addr;
      logic [riscv::XLEN/8-1:0] mem_rmask;
      logic [riscv::XLEN/8-1:0] mem_wmask;
      logic [riscv::XLEN-1:0]   mem_rdata;
      logic [riscv::XLEN-1:0]   mem_wdata;
   } rvfi_instr_t;
endpackage

// File: rtl/rvfi_commit_sequencer.sv
// rvfi_commit_sequencer
// Serialises the per-cycle RVFI commit records of all commit ports into one
// in-order stream through a FIFO, detects the tohost termination store and a
// cycle-limit timeout.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   rvfi_i         commit records, one per commit port
//   tohost_addr_i  tohost address (0 disables termination detection)
//   timeout_i      cycle limit (0 disables timeout)
//   out_valid_o    head record valid
//   out_ready_i    consumer accepts head record
//   out_rvfi_o     head record
//   out_port_o     commit port the head record came from
//   level_o        FIFO occupancy
//   overflow_o     sticky: a cycle's records were dropped
//   done_o         sticky: termination record dequeued
//   exit_code_o    mem_wdata of the terminating record
//   timeout_o      sticky: cycle limit exceeded before done
module rvfi_commit_sequencer #(
   parameter int NR_COMMIT_PORTS = 2,
   parameter int DEPTH           = 8,
   localparam int PORT_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
   input  logic [riscv::XLEN-1:0]                      tohost_addr_i,
   input  logic [31:0]                                 timeout_i,
   output logic                                        out_valid_o,
   input  logic                                        out_ready_i,
   output rvfi_pkg::rvfi_instr_t                       out_rvfi_o,
   output logic [PORT_W-1:0]                           out_port_o,
   output logic [LVL_W-1:0]                            level_o,
   output logic                                        overflow_o,
   output logic                                        done_o,
   output logic [riscv::XLEN-1:0]                      exit_code_o,
   output logic                                        timeout_o
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;

   state_t                state_q, state_d;
   rvfi_pkg::rvfi_instr_t mem_q  [DEPTH];
   logic [PORT_W-1:0]     port_q [DEPTH];
   logic [PTR_W-1:0]      wptr_q, rptr_q;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [LVL_W-1:0]      n_elig, free_slots;
   logic [NR_COMMIT_PORTS-1:0] elig;
   logic [PTR_W-1:0]      widx [NR_COMMIT_PORTS];
   logic                  deq, enq_allowed, drop, wr_en;
   logic                  done_set, timeout_set;
   logic [31:0]           cyc_q, cyc_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   function automatic logic is_term(input rvfi_pkg::rvfi_instr_t r,
                                    input logic [riscv::XLEN-1:0] th);
      return r.valid && (r.rd_addr == 5'd0) && (r.mem_wmask != '0) &&
             (r.mem_addr == th) && (th != '0) && (r.mem_wdata != '0);
   endfunction

   assign out_valid_o = (level_q != '0);
   assign level_o     = level_q;
   assign out_rvfi_o  = mem_q[rptr_q];
   assign out_port_o  = port_q[rptr_q];

   // Eligible records are packed densely from the write pointer in port
   // order, so each port's slot is wptr plus the number of eligible
   // lower-numbered ports.
   always_comb begin
      elig   = '0;
      n_elig = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         elig[i] = rvfi_i[i].valid | rvfi_i[i].trap;
         widx[i] = wptr_q + n_elig[PTR_W-1:0];
         n_elig  = n_elig + LVL_W'(elig[i]);
      end
   end

   always_comb begin
      deq         = out_valid_o & out_ready_i;
      // A same-cycle pop frees one slot for this cycle's writes.
      free_slots  = LVL_W'(DEPTH) - level_q + LVL_W'(deq);
      enq_allowed = (state_q == RUN);
      drop        = enq_allowed && (n_elig > free_slots);
      wr_en       = enq_allowed && !drop && (n_elig != '0);
      level_d     = level_q + (wr_en ? n_elig : '0) - LVL_W'(deq);
      done_set    = deq && is_term(out_rvfi_o, tohost_addr_i) && !done_o && !timeout_o;
      cyc_d       = sat_inc(cyc_q);
      // Timeout rises on the edge where the counter first exceeds the limit;
      // a termination dequeued on that same edge takes precedence.
      timeout_set = (timeout_i != 32'd0) && (cyc_d > timeout_i) &&
                    !done_o && !done_set && !timeout_o;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (done_set)         state_d = DRAIN;
            else if (timeout_set) state_d = IDLE;
         end
         DRAIN:   if (level_q == '0) state_d = IDLE;
         IDLE:    state_d = IDLE;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         overflow_o  <= 1'b0;
         done_o      <= 1'b0;
         timeout_o   <= 1'b0;
         exit_code_o <= '0;
         cyc_q       <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_q + (wr_en ? n_elig[PTR_W-1:0] : '0);
         rptr_q     <= rptr_q + PTR_W'(deq);
         level_q    <= level_d;
         overflow_o <= overflow_o | drop;
         done_o     <= done_o | done_set;
         timeout_o  <= timeout_o | timeout_set;
         cyc_q      <= cyc_d;
         if (done_set) exit_code_o <= out_rvfi_o.mem_wdata;
      end
   end

   // Storage carries no reset; occupancy alone decides what is meaningful.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (elig[i]) begin
               mem_q[widx[i]]  <= rvfi_i[i];
               port_q[widx[i]] <= PORT_W'(i);
            end
         end
      end
   end

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Bench for rvfi_commit_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_rvfi_commit_sequencer;
   import rvfi_pkg::*;

   localparam int NR    = 2;
   localparam int DEPTH = 8;
   localparam int PW    = 1;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic                    clk;
   logic                    rst_ni;
   rvfi_instr_t [NR-1:0]    rvfi;
   logic [riscv::XLEN-1:0]  tohost;
   logic [31:0]             tlimit;
   logic                    out_valid;
   logic                    out_ready;
   rvfi_instr_t             out_rvfi;
   logic [PW-1:0]           out_port;
   logic [LW-1:0]           level;
   logic                    overflow;
   logic                    done;
   logic [riscv::XLEN-1:0]  exit_code;
   logic                    tmo;

   rvfi_commit_sequencer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .rvfi_i(rvfi), .tohost_addr_i(tohost),
      .timeout_i(tlimit), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_rvfi_o(out_rvfi), .out_port_o(out_port), .level_o(level),
      .overflow_o(overflow), .done_o(done), .exit_code_o(exit_code),
      .timeout_o(tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model state
   typedef struct { rvfi_instr_t rec; int port; } ent_t;
   ent_t                   q[$];
   bit                     m_over, m_done, m_to;
   logic [riscv::XLEN-1:0] m_exit;
   longint unsigned        m_cnt;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rec(input string tag, input rvfi_instr_t obs, input rvfi_instr_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed pc=%h order=%h expected pc=%h order=%h",
                tag, obs.pc_rdata, obs.order, exp.pc_rdata, exp.order);
      end
   endtask

   function automatic bit m_term(input rvfi_instr_t r);
      return r.valid && r.rd_addr == 0 && r.mem_wmask != 0 && tohost != 0 &&
             r.mem_addr == tohost && r.mem_wdata != 0;
   endfunction

   function automatic rvfi_instr_t mk(input bit v, input bit t, input logic [63:0] pc);
      rvfi_instr_t r;
      r = '0;
      r.valid     = v;
      r.trap      = t;
      r.pc_rdata  = pc;
      r.order     = {$urandom, $urandom};
      r.insn      = $urandom;
      r.rd_addr   = 5'($urandom);
      r.rd_wdata  = {$urandom, $urandom};
      r.mem_addr  = {$urandom, $urandom} | 64'h1;   // odd: never a tohost hit
      r.mem_wmask = 8'($urandom);
      r.mem_wdata = {$urandom, $urandom};
      return r;
   endfunction

   function automatic rvfi_instr_t mk_term(input logic [63:0] pc, input logic [63:0] code);
      rvfi_instr_t r;
      r = mk(1'b1, 1'b0, pc);
      r.rd_addr   = 5'd0;
      r.mem_wmask = 8'h0F;
      r.mem_addr  = tohost;
      r.mem_wdata = code;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_over = 0; m_done = 0; m_to = 0; m_exit = '0; m_cnt = 0;
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("level", 64'(level), 64'(q.size()));
      if (q.size() != 0) begin
         chk_rec("head_rec", out_rvfi, q[0].rec);
         chk("head_port", 64'(out_port), 64'(q[0].port));
      end
      chk("overflow", 64'(overflow), 64'(m_over));
      chk("done", 64'(done), 64'(m_done));
      chk("timeout", 64'(tmo), 64'(m_to));
      chk("exit_code", exit_code, m_exit);
   endtask

   // Behaviour of one clock edge, from the commit/FIFO rules.
   task automatic model_step();
      bit pop, done_now;
      int n;
      pop = (q.size() != 0) && out_ready;
      done_now = 0;
      if (pop && !m_done && !m_to && m_term(q[0].rec)) begin
         done_now = 1;
         m_exit = q[0].rec.mem_wdata;
      end
      if (!m_done && !m_to) begin
         n = 0;
         for (int i = 0; i < NR; i++) if (rvfi[i].valid || rvfi[i].trap) n++;
         if (n > DEPTH - q.size() + (pop ? 1 : 0)) m_over = 1;
         else
            for (int i = 0; i < NR; i++)
               if (rvfi[i].valid || rvfi[i].trap) q.push_back('{rec: rvfi[i], port: i});
      end
      if (pop) void'(q.pop_front());
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (tlimit != 0 && m_cnt > tlimit && !m_done && !done_now && !m_to) m_to = 1;
      if (done_now) m_done = 1;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ports();
      rvfi = '0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni = 1'b0; rvfi = '0; tohost = '0; tlimit = '0; out_ready = 1'b0;
      #2;
      do_reset();

      // Two ports in one cycle come out in port order on consecutive cycles
      out_ready = 1'b1;
      rvfi[0] = mk(1, 0, 64'h100);
      rvfi[1] = mk(1, 0, 64'h104);
      cycle();
      idle_ports();
      chk("pair_first_pc", out_rvfi.pc_rdata, 64'h100);
      chk("pair_first_port", 64'(out_port), 64'd0);
      cycle();
      chk("pair_second_pc", out_rvfi.pc_rdata, 64'h104);
      chk("pair_second_port", 64'(out_port), 64'd1);
      cycle();
      chk("pair_drained", 64'(out_valid), 64'd0);

      // Random traffic
      for (int k = 0; k < 250; k++) begin
         for (int i = 0; i < NR; i++)
            rvfi[i] = mk($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                         64'(32'h1000 + 4 * (2 * k + i)));
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      idle_ports();

      // Fill to full, pop-credit accept, then overflow
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rvfi[0] = mk(1, 0, 64'(32'h2000 + 8 * k));
         rvfi[1] = mk(0, 1, 64'(32'h2004 + 8 * k));
         cycle();
      end
      chk("full_level", 64'(level), 64'd8);
      out_ready = 1'b1;
      rvfi[0] = '0;
      rvfi[1] = mk(1, 0, 64'h2100);
      cycle();
      chk("credit_level", 64'(level), 64'd8);
      chk("credit_no_overflow", 64'(overflow), 64'd0);
      out_ready = 1'b0;
      rvfi[0] = mk(1, 0, 64'h2200);
      rvfi[1] = mk(1, 0, 64'h2204);
      cycle();
      chk("ovf_level", 64'(level), 64'd8);
      chk("ovf_flag", 64'(overflow), 64'd1);
      idle_ports();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      chk("pre_reset_level", 64'(level), 64'd5);

      // Asynchronous reset mid-operation, checked before any clock edge
      out_ready = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("async_level", 64'(level), 64'd0);
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_overflow", 64'(overflow), 64'd0);
      chk("async_done", 64'(done), 64'd0);
      chk("async_timeout", 64'(tmo), 64'd0);
      do_reset();

      // Termination through tohost
      tohost = 64'h8000_1000;
      out_ready = 1'b1;
      rvfi[0] = mk_term(64'h3000, 64'h1);
      rvfi[1] = mk(1, 0, 64'h3004);
      cycle();
      rvfi[0] = mk(1, 0, 64'h3008);
      rvfi[1] = mk_term(64'h300C, 64'h5);
      cycle();
      chk("term_done", 64'(done), 64'd1);
      chk("term_exit", exit_code, 64'h1);
      for (int k = 0; k < 6; k++) begin
         rvfi[0] = mk(1, 0, 64'(32'h3100 + 8 * k));
         rvfi[1] = mk(1, 0, 64'(32'h3104 + 8 * k));
         cycle();
      end
      chk("term_drained", 64'(level), 64'd0);
      chk("term_exit_kept", exit_code, 64'h1);
      idle_ports();

      // Timeout without termination
      tohost = '0;
      tlimit = 32'd100;
      do_reset();
      while (m_cnt < 100) cycle();
      chk("tmo_before", 64'(tmo), 64'd0);
      cycle();
      chk("tmo_at_101", 64'(tmo), 64'd1);
      rvfi[0] = mk(1, 0, 64'h4000);
      cycle();
      idle_ports();
      chk("tmo_no_enqueue", 64'(level), 64'd0);
      cycle();

      // Termination dequeued on the same edge the limit is crossed
      tohost = 64'h8000_1000;
      do_reset();
      out_ready = 1'b0;
      rvfi[0] = mk_term(64'h5000, 64'h2A);
      cycle();
      idle_ports();
      while (m_cnt < 100) cycle();
      out_ready = 1'b1;
      cycle();
      chk("race_done", 64'(done), 64'd1);
      chk("race_timeout", 64'(tmo), 64'd0);
      chk("race_exit", exit_code, 64'h2A);
      for (int k = 0; k < 3; k++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
